// File: rtl/operand_collector.sv
// operand_collector: read-side initiator for a 4-bank register file.
// Holds issued instructions in NUM_OC collectors (two operand slots each),
// arbitrates one read per bank per cycle, routes returned bank data back to
// the requesting slot by ocid, and dispatches complete collectors on a
// valid/ready port. ocid = {collector[1:0], slot}; the 3-bit ocid fixes
// NUM_OC at 4.
module operand_collector #(
   parameter int NUM_OC = 4,
   parameter int DATA_W = 256,
   parameter int TAG_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic              in_rs2_en,
   input  logic [TAG_W-1:0]  in_tag,
   output logic [2:0]        RF_Addr_0,
   output logic [2:0]        RF_Addr_1,
   output logic [2:0]        RF_Addr_2,
   output logic [2:0]        RF_Addr_3,
   output logic [2:0]        ocid_out_0,
   output logic [2:0]        ocid_out_1,
   output logic [2:0]        ocid_out_2,
   output logic [2:0]        ocid_out_3,
   input  logic              RF_WR_0,
   input  logic              RF_WR_1,
   input  logic              RF_WR_2,
   input  logic              RF_WR_3,
   input  logic [DATA_W-1:0] DataOut_0,
   input  logic [DATA_W-1:0] DataOut_1,
   input  logic [DATA_W-1:0] DataOut_2,
   input  logic [DATA_W-1:0] DataOut_3,
   input  logic [2:0]        ocid_0,
   input  logic [2:0]        ocid_1,
   input  logic [2:0]        ocid_2,
   input  logic [2:0]        ocid_3,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [TAG_W-1:0]  out_tag,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2
);

   localparam int NUM_REQ  = 2 * NUM_OC;
   localparam int NUM_BANK = 4;

   typedef enum logic [1:0] {OC_FREE, OC_COLLECT, OC_READY} oc_state_t;
   typedef enum logic [1:0] {SL_NEED, SL_INFLIGHT, SL_HAVE} sl_state_t;

   // First set bit at or after ptr, wrapping; returns ptr when nothing is set.
   function automatic logic [2:0] rr_pick8(input logic [7:0] req, input logic [2:0] ptr);
      logic [2:0] idx;
      rr_pick8 = ptr;
      for (int i = 7; i >= 0; i--) begin
         idx = ptr + 3'(i);
         if (req[idx]) rr_pick8 = idx;
      end
   endfunction

   function automatic logic [1:0] rr_pick4(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      rr_pick4 = ptr;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) rr_pick4 = idx;
      end
   endfunction

   // ---- per-bank port bundling ----
   logic [NUM_BANK-1:0] w_rf_wr;
   logic [DATA_W-1:0]   w_din      [NUM_BANK];
   logic [2:0]          w_ocid_in  [NUM_BANK];
   logic [2:0]          w_rf_addr  [NUM_BANK];
   logic [2:0]          w_ocid_out [NUM_BANK];

   assign w_rf_wr      = {RF_WR_3, RF_WR_2, RF_WR_1, RF_WR_0};
   assign w_din[0]     = DataOut_0;
   assign w_din[1]     = DataOut_1;
   assign w_din[2]     = DataOut_2;
   assign w_din[3]     = DataOut_3;
   assign w_ocid_in[0] = ocid_0;
   assign w_ocid_in[1] = ocid_1;
   assign w_ocid_in[2] = ocid_2;
   assign w_ocid_in[3] = ocid_3;
   assign RF_Addr_0    = w_rf_addr[0];
   assign RF_Addr_1    = w_rf_addr[1];
   assign RF_Addr_2    = w_rf_addr[2];
   assign RF_Addr_3    = w_rf_addr[3];
   assign ocid_out_0   = w_ocid_out[0];
   assign ocid_out_1   = w_ocid_out[1];
   assign ocid_out_2   = w_ocid_out[2];
   assign ocid_out_3   = w_ocid_out[3];

   // ---- state ----
   oc_state_t           r_oc_state     [NUM_OC];
   oc_state_t           w_oc_state_nxt [NUM_OC];
   sl_state_t           r_sl_state     [NUM_REQ];
   sl_state_t           w_sl_state_nxt [NUM_REQ];
   logic [TAG_W-1:0]    r_oc_tag       [NUM_OC];
   logic [1:0]          r_sl_bank      [NUM_REQ];
   logic [2:0]          r_sl_addr      [NUM_REQ];
   logic [DATA_W-1:0]   r_sl_data      [NUM_REQ];
   logic [2:0]          r_rr_ptr       [NUM_BANK];
   logic [NUM_BANK-1:0] r_issue_v;
   logic [2:0]          r_issue_ocid   [NUM_BANK];
   logic [1:0]          r_disp_ptr;
   logic                r_hold_v;
   logic [1:0]          r_hold_sel;

   // ---- combinational ----
   logic                w_free_any;
   logic [1:0]          w_alloc_oc;
   logic                w_accept;
   logic [NUM_REQ-1:0]  w_req        [NUM_BANK];
   logic [NUM_BANK-1:0] w_gnt_v;
   logic [2:0]          w_gnt_id     [NUM_BANK];
   logic [NUM_REQ-1:0]  w_granted;
   logic [NUM_REQ-1:0]  w_fill;
   logic [DATA_W-1:0]   w_fill_data  [NUM_REQ];
   logic [NUM_OC-1:0]   w_ready_vec;
   logic [1:0]          w_sel;
   logic                w_handshake;

   // Allocation: lowest-index FREE collector; in_ready depends only on registered state.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_free_any = 1'b0;
      w_alloc_oc = '0;
      for (int c = NUM_OC - 1; c >= 0; c--) begin
         if (r_oc_state[c] == OC_FREE) begin
            w_free_any = 1'b1;
            w_alloc_oc = 2'(c);
         end
      end
   end

   assign w_accept = in_valid & w_free_any;

   // Per-bank round-robin over the eight slots still needing a read on that bank.
   always_comb begin
      w_granted = '0;
      for (int n = 0; n < NUM_BANK; n++) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            w_req[n][r] = (r_sl_state[r] == SL_NEED) && (r_oc_state[r / 2] == OC_COLLECT) &&
                          (r_sl_bank[r] == 2'(n)) && !w_rf_wr[n];
         end
         w_gnt_v[n]  = |w_req[n];
         w_gnt_id[n] = rr_pick8(w_req[n], r_rr_ptr[n]);
         if (w_gnt_v[n]) w_granted[w_gnt_id[n]] = 1'b1;
         w_rf_addr[n]  = w_gnt_v[n] ? r_sl_addr[w_gnt_id[n]] : 3'd0;
         w_ocid_out[n] = w_gnt_v[n] ? w_gnt_id[n] : 3'd0;
      end
   end

   // Return routing: a bank that issued last cycle delivers its data to the slot named by ocid_n.
   always_comb begin
      w_fill = '0;
      for (int r = 0; r < NUM_REQ; r++) w_fill_data[r] = '0;
      for (int n = 0; n < NUM_BANK; n++) begin
         if (r_issue_v[n]) begin
            w_fill[w_ocid_in[n]]      = 1'b1;
            w_fill_data[w_ocid_in[n]] = w_din[n];
         end
      end
   end

   // Dispatch selection: round-robin among READY collectors, frozen while the consumer stalls.
   always_comb begin
      for (int c = 0; c < NUM_OC; c++) w_ready_vec[c] = (r_oc_state[c] == OC_READY);
      w_sel = r_hold_v ? r_hold_sel : rr_pick4(w_ready_vec, r_disp_ptr);
   end

   assign w_handshake = out_valid & out_ready;

   // FSM state register for collectors and slots.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         for (int c = 0; c < NUM_OC; c++) r_oc_state[c] <= OC_FREE;
         // Idle slots rest in HAVE so a FREE collector never requests a read.
         for (int r = 0; r < NUM_REQ; r++) r_sl_state[r] <= SL_HAVE;
      end else begin
         r_oc_state <= w_oc_state_nxt;
         r_sl_state <= w_sl_state_nxt;
      end
   end

   // FSM next state: slot fills count toward READY in the same cycle they land.
   always_comb begin
      for (int r = 0; r < NUM_REQ; r++) begin
         w_sl_state_nxt[r] = r_sl_state[r];
         if (w_fill[r] && (r_sl_state[r] == SL_INFLIGHT)) w_sl_state_nxt[r] = SL_HAVE;
         if (w_granted[r]) w_sl_state_nxt[r] = SL_INFLIGHT;
         if (w_accept && (w_alloc_oc == 2'(r / 2)))
            w_sl_state_nxt[r] = ((r % 2 == 1) && !in_rs2_en) ? SL_HAVE : SL_NEED;
      end
      for (int c = 0; c < NUM_OC; c++) begin
         w_oc_state_nxt[c] = r_oc_state[c];
         case (r_oc_state[c])
            OC_FREE:    if (w_accept && (w_alloc_oc == 2'(c))) w_oc_state_nxt[c] = OC_COLLECT;
            OC_COLLECT: if ((w_sl_state_nxt[2*c] == SL_HAVE) && (w_sl_state_nxt[2*c+1] == SL_HAVE))
                           w_oc_state_nxt[c] = OC_READY;
            OC_READY:   if (w_handshake && (w_sel == 2'(c))) w_oc_state_nxt[c] = OC_FREE;
            default:    w_oc_state_nxt[c] = OC_FREE;
         endcase
      end
   end

   // FSM outputs: presented collector's payload, zero when nothing is READY.
   always_comb begin
      in_ready  = w_free_any;
      out_valid = |w_ready_vec;
      out_tag   = out_valid ? r_oc_tag[w_sel]            : '0;
      out_op1   = out_valid ? r_sl_data[{w_sel, 1'b0}]   : '0;
      out_op2   = out_valid ? r_sl_data[{w_sel, 1'b1}]   : '0;
   end

   // Arbiter pointers, issue-valid pipe and dispatch hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < NUM_BANK; n++) begin
            r_rr_ptr[n]     <= '0;
            r_issue_ocid[n] <= '0;
         end
         r_issue_v  <= '0;
         r_disp_ptr <= '0;
         r_hold_v   <= 1'b0;
         r_hold_sel <= '0;
      end else begin
         for (int n = 0; n < NUM_BANK; n++) begin
            if (w_gnt_v[n]) r_rr_ptr[n] <= w_gnt_id[n] + 3'd1;
            r_issue_ocid[n] <= w_gnt_id[n];
         end
         r_issue_v  <= w_gnt_v;
         if (w_handshake) r_disp_ptr <= w_sel + 2'd1;
         r_hold_v   <= out_valid & ~out_ready;
         r_hold_sel <= w_sel;
      end
   end

   // Payload capture: tag, operand addresses on accept; operand data on return.
   always_ff @(posedge clk) begin
      // NOTE: payload storage is not reset; the collector/slot state guards every read of it.
      if (w_accept) begin
         r_oc_tag[w_alloc_oc]           <= in_tag;
         r_sl_bank[{w_alloc_oc, 1'b0}] <= in_rs1[1:0];
         r_sl_addr[{w_alloc_oc, 1'b0}] <= in_rs1[4:2];
         r_sl_bank[{w_alloc_oc, 1'b1}] <= in_rs2[1:0];
         r_sl_addr[{w_alloc_oc, 1'b1}] <= in_rs2[4:2];
         if (!in_rs2_en) r_sl_data[{w_alloc_oc, 1'b1}] <= '0;
      end
      for (int r = 0; r < NUM_REQ; r++) begin
         if (w_fill[r] && (r_sl_state[r] == SL_INFLIGHT)) r_sl_data[r] <= w_fill_data[r];
      end
   end

   // The register file must echo exactly the ocid issued one cycle earlier.
   for (genvar n = 0; n < NUM_BANK; n++) begin : g_ocid_chk
      a_ocid_match: assert property (@(posedge clk) disable iff (rst)
         r_issue_v[n] |-> (w_ocid_in[n] == r_issue_ocid[n]));
   end

endmodule

// File: tb/tb_operand_collector.sv
// tb_operand_collector: directed self-checking bench for operand_collector.
// A small register-file model delays ocid_out_n by one cycle and returns a
// word derived from {bank, addr}.
module tb_operand_collector;

   localparam int DATA_W = 256;
   localparam int TAG_W  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_ready, in_rs2_en;
   logic [4:0]        in_rs1, in_rs2;
   logic [TAG_W-1:0]  in_tag;
   logic [2:0]        RF_Addr_0, RF_Addr_1, RF_Addr_2, RF_Addr_3;
   logic [2:0]        ocid_out_0, ocid_out_1, ocid_out_2, ocid_out_3;
   logic              RF_WR_0, RF_WR_1, RF_WR_2, RF_WR_3;
   logic [DATA_W-1:0] DataOut_0, DataOut_1, DataOut_2, DataOut_3;
   logic [2:0]        ocid_0, ocid_1, ocid_2, ocid_3;
   logic              out_valid, out_ready;
   logic [TAG_W-1:0]  out_tag;
   logic [DATA_W-1:0] out_op1, out_op2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   operand_collector #(.NUM_OC(4), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs2_en(in_rs2_en), .in_tag(in_tag),
      .RF_Addr_0(RF_Addr_0), .RF_Addr_1(RF_Addr_1), .RF_Addr_2(RF_Addr_2), .RF_Addr_3(RF_Addr_3),
      .ocid_out_0(ocid_out_0), .ocid_out_1(ocid_out_1), .ocid_out_2(ocid_out_2), .ocid_out_3(ocid_out_3),
      .RF_WR_0(RF_WR_0), .RF_WR_1(RF_WR_1), .RF_WR_2(RF_WR_2), .RF_WR_3(RF_WR_3),
      .DataOut_0(DataOut_0), .DataOut_1(DataOut_1), .DataOut_2(DataOut_2), .DataOut_3(DataOut_3),
      .ocid_0(ocid_0), .ocid_1(ocid_1), .ocid_2(ocid_2), .ocid_3(ocid_3),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_tag(out_tag), .out_op1(out_op1), .out_op2(out_op2)
   );

   // Register-file word for a given bank and bank address.
   function automatic logic [DATA_W-1:0] rf_data(input int bank, input logic [2:0] addr);
      logic [31:0] w;
      w = 32'hD000_0000 | (32'(bank) << 8) | 32'(addr);
      return {8{w}};
   endfunction

   // Register-file model: address and ocid registered, data valid the cycle after issue.
   logic [2:0] rf_addr_q [4];
   logic [2:0] rf_ocid_q [4];
   always @(posedge clk) begin
      rf_addr_q[0] <= RF_Addr_0;  rf_ocid_q[0] <= ocid_out_0;
      rf_addr_q[1] <= RF_Addr_1;  rf_ocid_q[1] <= ocid_out_1;
      rf_addr_q[2] <= RF_Addr_2;  rf_ocid_q[2] <= ocid_out_2;
      rf_addr_q[3] <= RF_Addr_3;  rf_ocid_q[3] <= ocid_out_3;
   end
   assign DataOut_0 = rf_data(0, rf_addr_q[0]);
   assign DataOut_1 = rf_data(1, rf_addr_q[1]);
   assign DataOut_2 = rf_data(2, rf_addr_q[2]);
   assign DataOut_3 = rf_data(3, rf_addr_q[3]);
   assign ocid_0 = rf_ocid_q[0];
   assign ocid_1 = rf_ocid_q[1];
   assign ocid_2 = rf_ocid_q[2];
   assign ocid_3 = rf_ocid_q[3];

   task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic en, input logic [7:0] tag);
      in_valid  = 1'b1;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_rs2_en = en;
      in_tag    = tag;
   endtask

   // Watchdog: directed sequence is a few hundred ns long.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rs2_en = 1'b0; in_tag = '0;
      out_ready = 1'b1; RF_WR_0 = 1'b0; RF_WR_1 = 1'b0; RF_WR_2 = 1'b0; RF_WR_3 = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst in_ready", in_ready, 1);
      check("rst out_valid", out_valid, 0);
      check("rst out_tag", out_tag, 0);
      check("rst out_op1", out_op1, 0);
      check("rst RF_Addr_3", RF_Addr_3, 0);
      check("rst ocid_out_2", ocid_out_2, 0);
      rst = 1'b0;

      // ---- 1: rs1=5 (bank1/addr1), rs2=10 (bank2/addr2) ----
      @(negedge clk); offer(5, 10, 1, 8'h11); #1;
      check("t1 in_ready", in_ready, 1);
      @(negedge clk); in_valid = 1'b0; #1;
      check("t1 RF_Addr_1", RF_Addr_1, 1);
      check("t1 ocid_out_1", ocid_out_1, 0);
      check("t1 RF_Addr_2", RF_Addr_2, 2);
      check("t1 ocid_out_2", ocid_out_2, 1);
      check("t1 out_valid c1", out_valid, 0);
      @(negedge clk); #1;
      check("t1 out_valid c2", out_valid, 0);
      check("t1 RF_Addr_1 idle", RF_Addr_1, 0);
      @(negedge clk); #1;
      check("t1 out_valid c3", out_valid, 1);
      check("t1 out_tag", out_tag, 8'h11);
      check("t1 out_op1", out_op1, rf_data(1, 1));
      check("t1 out_op2", out_op2, rf_data(2, 2));
      @(negedge clk); #1;
      check("t1 out_valid after", out_valid, 0);

      // ---- 2: rs1=4, rs2=8, both bank0: serialized reads ----
      @(negedge clk); offer(4, 8, 1, 8'h22);
      @(negedge clk); in_valid = 1'b0; #1;
      check("t2 RF_Addr_0 c1", RF_Addr_0, 1);
      check("t2 ocid_out_0 c1", ocid_out_0, 0);
      @(negedge clk); #1;
      check("t2 RF_Addr_0 c2", RF_Addr_0, 2);
      check("t2 ocid_out_0 c2", ocid_out_0, 1);
      check("t2 out_valid c2", out_valid, 0);
      @(negedge clk); #1;
      check("t2 out_valid c3", out_valid, 0);
      @(negedge clk); #1;
      check("t2 out_valid c4", out_valid, 1);
      check("t2 out_tag", out_tag, 8'h22);
      check("t2 out_op1", out_op1, rf_data(0, 1));
      check("t2 out_op2", out_op2, rf_data(0, 2));
      @(negedge clk); #1;
      check("t2 out_valid after", out_valid, 0);

      // ---- 3: four single-operand bank3 accepts, fifth stalls ----
      @(negedge clk); out_ready = 1'b0; offer(7, 0, 0, 8'h30); #1;
      check("t3 in_ready a0", in_ready, 1);
      @(negedge clk); offer(11, 0, 0, 8'h31); #1;
      check("t3 in_ready a1", in_ready, 1);
      check("t3 RF_Addr_3 oc0", RF_Addr_3, 1);
      check("t3 ocid_out_3 oc0", ocid_out_3, 0);
      @(negedge clk); offer(15, 0, 0, 8'h32); #1;
      check("t3 in_ready a2", in_ready, 1);
      check("t3 RF_Addr_3 oc1", RF_Addr_3, 2);
      check("t3 ocid_out_3 oc1", ocid_out_3, 2);
      @(negedge clk); offer(19, 0, 0, 8'h33); #1;
      check("t3 in_ready a3", in_ready, 1);
      check("t3 RF_Addr_3 oc2", RF_Addr_3, 3);
      check("t3 ocid_out_3 oc2", ocid_out_3, 4);
      @(negedge clk); offer(5, 0, 0, 8'h34); #1;
      check("t3 in_ready full", in_ready, 0);
      check("t3 RF_Addr_3 oc3", RF_Addr_3, 4);
      check("t3 ocid_out_3 oc3", ocid_out_3, 6);
      check("t3 out_valid held", out_valid, 1);
      check("t3 out_tag held c4", out_tag, 8'h30);
      @(negedge clk); #1;
      check("t3 in_ready stall", in_ready, 0);
      check("t3 out_tag held c5", out_tag, 8'h30);
      @(negedge clk); out_ready = 1'b1; #1;
      check("t3 in_ready pre-disp", in_ready, 0);
      check("t3 disp0 tag", out_tag, 8'h30);
      check("t3 disp0 op1", out_op1, rf_data(3, 1));
      check("t3 disp0 op2", out_op2, 0);
      @(negedge clk); #1;
      check("t3 in_ready freed", in_ready, 1);
      check("t3 disp1 tag", out_tag, 8'h31);
      check("t3 5th not yet", RF_Addr_1, 0);
      @(negedge clk); in_valid = 1'b0; #1;
      check("t3 5th RF_Addr_1", RF_Addr_1, 1);
      check("t3 5th ocid_out_1", ocid_out_1, 0);
      check("t3 disp2 tag", out_tag, 8'h32);
      @(negedge clk); #1;
      check("t3 disp3 tag", out_tag, 8'h33);
      @(negedge clk); #1;
      check("t3 5th out_valid", out_valid, 1);
      check("t3 5th out_tag", out_tag, 8'h34);
      check("t3 5th out_op1", out_op1, rf_data(1, 1));
      check("t3 5th out_op2", out_op2, 0);
      @(negedge clk); #1;
      check("t3 drained", out_valid, 0);

      // ---- 4: bank2 blocked by writeback for 3 cycles ----
      @(negedge clk); RF_WR_2 = 1'b1; offer(5, 14, 1, 8'h40);
      @(negedge clk); in_valid = 1'b0; #1;
      check("t4 RF_Addr_1", RF_Addr_1, 1);
      check("t4 RF_Addr_2 blk1", RF_Addr_2, 0);
      check("t4 ocid_out_2 blk1", ocid_out_2, 0);
      @(negedge clk); #1;
      check("t4 RF_Addr_2 blk2", RF_Addr_2, 0);
      check("t4 ocid_out_2 blk2", ocid_out_2, 0);
      @(negedge clk); #1;
      check("t4 RF_Addr_2 blk3", RF_Addr_2, 0);
      check("t4 ocid_out_2 blk3", ocid_out_2, 0);
      @(negedge clk); RF_WR_2 = 1'b0; #1;
      check("t4 RF_Addr_2 rel", RF_Addr_2, 3);
      check("t4 ocid_out_2 rel", ocid_out_2, 1);
      @(negedge clk); #1;
      check("t4 out_valid c5", out_valid, 0);
      @(negedge clk); #1;
      check("t4 out_valid c6", out_valid, 1);
      check("t4 out_tag", out_tag, 8'h40);
      check("t4 out_op1", out_op1, rf_data(1, 1));
      check("t4 out_op2", out_op2, rf_data(2, 3));
      @(negedge clk); #1;
      check("t4 drained", out_valid, 0);

      // ---- 5: consumer stalls with two READY collectors ----
      @(negedge clk); out_ready = 1'b0; offer(9, 18, 1, 8'h50);
      @(negedge clk); offer(12, 31, 1, 8'h51);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); #1;
      check("t5 first ready", out_tag, 8'h50);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         check("t5 stall valid", out_valid, 1);
         check("t5 stall tag", out_tag, 8'h50);
         check("t5 stall op1", out_op1, rf_data(1, 2));
         check("t5 stall op2", out_op2, rf_data(2, 4));
         check("t5 stall in_ready", in_ready, 1);
      end
      @(negedge clk); out_ready = 1'b1; #1;
      check("t5 disp A tag", out_tag, 8'h50);
      @(negedge clk); #1;
      check("t5 disp B tag", out_tag, 8'h51);
      check("t5 disp B op1", out_op1, rf_data(0, 3));
      check("t5 disp B op2", out_op2, rf_data(3, 7));
      @(negedge clk); #1;
      check("t5 drained", out_valid, 0);

      // ---- 6: reset pulse with reads in flight and issuing ----
      @(negedge clk); offer(13, 22, 1, 8'h60);
      @(negedge clk); offer(17, 0, 0, 8'h61); #1;
      check("t6 RF_Addr_1 X", RF_Addr_1, 3);
      check("t6 RF_Addr_2 X", RF_Addr_2, 5);
      @(negedge clk); in_valid = 1'b0; #1;
      check("t6 RF_Addr_1 Y", RF_Addr_1, 4);
      check("t6 ocid_out_1 Y", ocid_out_1, 2);
      #1 rst = 1'b1;
      #1;
      check("t6 rst out_valid", out_valid, 0);
      check("t6 rst RF_Addr_1", RF_Addr_1, 0);
      check("t6 rst ocid_out_1", ocid_out_1, 0);
      check("t6 rst in_ready", in_ready, 1);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      check("t6 stale ignored valid", out_valid, 0);
      check("t6 post RF_Addr_1", RF_Addr_1, 0);
      check("t6 post in_ready", in_ready, 1);
      @(negedge clk); #1;
      check("t6 stale ignored valid2", out_valid, 0);
      @(negedge clk); offer(5, 10, 1, 8'h62);
      @(negedge clk); in_valid = 1'b0; #1;
      check("t6 fresh RF_Addr_1", RF_Addr_1, 1);
      check("t6 fresh RF_Addr_2", RF_Addr_2, 2);
      check("t6 fresh ocid_out_2", ocid_out_2, 1);
      @(negedge clk); #1;
      check("t6 fresh out_valid c2", out_valid, 0);
      @(negedge clk); #1;
      check("t6 fresh out_valid", out_valid, 1);
      check("t6 fresh out_tag", out_tag, 8'h62);
      check("t6 fresh out_op1", out_op1, rf_data(1, 1));
      check("t6 fresh out_op2", out_op2, rf_data(2, 2));

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
